// File: rtl/enc_8b10b_pkg.sv
// Shared 8b/10b constants and the word-aligner state type.
package enc_8b10b_pkg;

  localparam logic [6:0] COMMA_RDN = 7'b0011111;
  localparam logic [6:0] COMMA_RDP = 7'b1100000;

  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} align_state_t;

  // A code group carries a comma when its leading seven bits match either disparity.
  function automatic logic is_comma(input logic [9:0] cg);
    return (cg[9:3] == COMMA_RDN) || (cg[9:3] == COMMA_RDP);
  endfunction

endpackage

// File: rtl/comma_detect_10b.sv
// Flags a comma at each of the ten bit offsets of a 20-bit receive window.
module comma_detect_10b
  import enc_8b10b_pkg::*;
(
  input  logic [19:0] win,
  output logic [9:0]  hit
);

  for (genvar p = 0; p < 10; p++) begin : g_hit
    assign hit[p] = is_comma(win[19-p -: 10]);
  end

endmodule

// File: rtl/comma_aligner_10b.sv
// Comma-hunting word aligner feeding the 8b/10b decoder; re-hunts on decoder violations.
module comma_aligner_10b
  import enc_8b10b_pkg::*;
#(
  parameter int unsigned N_VERIFY  = 3,
  parameter int unsigned ERR_LIMIT = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       DVI,
  input  logic [9:0] DI,
  input  logic       VIOL_IN,
  output logic       DVO,
  output logic [9:0] DO,
  output logic       LOCK,
  output logic [3:0] ALIGN_POS
);

  localparam int unsigned CNT_MAX = (N_VERIFY > ERR_LIMIT) ? N_VERIFY : ERR_LIMIT;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  logic [19:0]   win_q;
  logic [1:0]    fill_q;
  logic          dvi_q;
  align_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]    pos_q, pos_d, first_pos;
  logic [9:0]    hit, cand;
  logic          wv, any_hit, hit_pos, foreign, bad_word;

  comma_detect_10b u_detect (
    .win (win_q),
    .hit (hit)
  );

  // The window holds two fresh words only after a full fill and a DVI on the last edge.
  assign wv       = (fill_q == 2'd2) && dvi_q;
  assign any_hit  = |hit;
  assign hit_pos  = hit[pos_q];
  assign foreign  = any_hit && !hit_pos;
  assign bad_word = (DVO && VIOL_IN) || foreign;
  assign cand     = win_q[5'd19 - 5'(pos_q) -: 10];
  assign cnt_inc  = cnt_q + CW'(1);

  always_comb begin
    first_pos = '0;
    for (int p = 9; p >= 0; p--) begin
      if (hit[p]) first_pos = 4'(p);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    if (wv) begin
      case (state_q)
        HUNT: begin
          if (any_hit) begin
            state_d = VERIFY;
            pos_d   = first_pos;
            cnt_d   = '0;
          end
        end
        VERIFY: begin
          if (hit_pos) begin
            if (cnt_inc == CW'(N_VERIFY)) begin
              state_d = LOCKED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (any_hit) begin
            state_d = HUNT;
            cnt_d   = '0;
          end
        end
        LOCKED: begin
          if (bad_word) begin
            if (cnt_inc == CW'(ERR_LIMIT)) begin
              state_d = HUNT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (DVO) begin
            cnt_d = '0;
          end
        end
        default: begin
          state_d = HUNT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      win_q   <= '0;
      fill_q  <= '0;
      dvi_q   <= 1'b0;
      state_q <= HUNT;
      cnt_q   <= '0;
      pos_q   <= '0;
    end else begin
      if (DVI) begin
        win_q <= {win_q[9:0], DI};
        if (fill_q != 2'd2) fill_q <= fill_q + 2'd1;
      end
      dvi_q   <= DVI;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DVO       <= 1'b0;
      DO        <= '0;
      LOCK      <= 1'b0;
      ALIGN_POS <= '0;
    end else begin
      if (wv) begin
        DO  <= cand;
        DVO <= (state_q == LOCKED);
      end else begin
        DVO <= 1'b0;
      end
      LOCK      <= (state_d == LOCKED);
      ALIGN_POS <= pos_d;
    end
  end

endmodule

// File: tb/tb_comma_aligner_10b.sv
// Directed and randomized bench for comma_aligner_10b against a behavioural aligner model.
module tb_comma_aligner_10b;
  import enc_8b10b_pkg::*;

  localparam int N_VERIFY  = 3;
  localparam int ERR_LIMIT = 4;
  localparam logic [9:0] D21_5 = 10'b1010101010;
  localparam int ST_HUNT = 0, ST_VER = 1, ST_LOCK = 2;

  logic       CLK = 1'b0;
  logic       RST, DVI, VIOL_IN, DVO, LOCK;
  logic [9:0] DI, DO;
  logic [3:0] ALIGN_POS;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  comma_aligner_10b #(
    .N_VERIFY  (N_VERIFY),
    .ERR_LIMIT (ERR_LIMIT)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .DVI       (DVI),
    .DI        (DI),
    .VIOL_IN   (VIOL_IN),
    .DVO       (DVO),
    .DO        (DO),
    .LOCK      (LOCK),
    .ALIGN_POS (ALIGN_POS)
  );

  // Reference model: the last two raw words, plus the aligner's behaviour in plain integers.
  logic [9:0] m_w1, m_w0, m_do;
  int         m_fill, m_state, m_cnt, m_pos;
  bit         m_dvi_last, m_dvo, m_lock;
  int         m_apos;

  // Stimulus-side serializer state.
  logic [9:0] sent[$];
  logic [9:0] prev_cg;
  int         rot_r;
  bit         alt_k, kd_k;

  function automatic logic [9:0] m_cand(input logic [9:0] older, input logic [9:0] newer,
                                        input int p);
    logic [19:0] w;
    w = {older, newer};
    w = w >> (10 - p);
    return w[9:0];
  endfunction

  function automatic bit m_comma(input logic [9:0] c);
    int top;
    top = int'(c) / 8;
    return (top == 31) || (top == 96);
  endfunction

  function automatic logic [9:0] rotate(input logic [9:0] older, input logic [9:0] newer,
                                        input int r);
    logic [19:0] w;
    w = {older, newer};
    w = w >> r;
    return w[9:0];
  endfunction

  task automatic model_reset();
    m_w1 = '0; m_w0 = '0; m_do = '0;
    m_fill = 0; m_state = ST_HUNT; m_cnt = 0; m_pos = 0;
    m_dvi_last = 0; m_dvo = 0; m_lock = 0; m_apos = 0;
  endtask

  task automatic model_edge(input bit dvi, input logic [9:0] di, input bit viol);
    bit wv, anyh, hitp, foreign, old_dvo;
    int first;
    wv = (m_fill == 2) && m_dvi_last;
    if (wv) begin
      first = -1;
      anyh  = 0;
      for (int p = 0; p < 10; p++) begin
        if (m_comma(m_cand(m_w1, m_w0, p))) begin
          anyh = 1;
          if (first < 0) first = p;
        end
      end
      hitp    = m_comma(m_cand(m_w1, m_w0, m_pos));
      foreign = anyh && !hitp;
      old_dvo = m_dvo;
      m_do    = m_cand(m_w1, m_w0, m_pos);
      m_dvo   = (m_state == ST_LOCK);
      case (m_state)
        ST_HUNT: if (anyh) begin m_state = ST_VER; m_pos = first; m_cnt = 0; end
        ST_VER: begin
          if (hitp) begin
            m_cnt++;
            if (m_cnt == N_VERIFY) begin m_state = ST_LOCK; m_cnt = 0; end
          end else if (anyh) begin
            m_state = ST_HUNT; m_cnt = 0;
          end
        end
        default: begin
          if ((old_dvo && viol) || foreign) begin
            m_cnt++;
            if (m_cnt == ERR_LIMIT) begin m_state = ST_HUNT; m_cnt = 0; end
          end else if (old_dvo) begin
            m_cnt = 0;
          end
        end
      endcase
    end else begin
      m_dvo = 0;
    end
    if (dvi) begin
      m_w1 = m_w0;
      m_w0 = di;
      if (m_fill < 2) m_fill++;
    end
    m_dvi_last = dvi;
    m_lock = (m_state == ST_LOCK);
    m_apos = m_pos;
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, required %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit dvi, input logic [9:0] di, input bit viol);
    @(negedge CLK);
    DVI = dvi; DI = di; VIOL_IN = viol;
    @(posedge CLK);
    model_edge(dvi, di, viol);
    #1;
    chk("dvo", 10'(DVO), 10'(m_dvo));
    chk("do", DO, m_do);
    chk("lock", 10'(LOCK), 10'(m_lock));
    chk("align_pos", 10'(ALIGN_POS), 10'(m_apos));
  endtask

  task automatic send_cg(input logic [9:0] cg, input bit viol);
    step(1'b1, rotate(prev_cg, cg, rot_r), viol);
    prev_cg = cg;
    sent.push_back(cg);
  endtask

  // Alternating K28.5 RDN/RDP stream.
  task automatic alt(input int n, input bit viol);
    for (int i = 0; i < n; i++) begin
      send_cg(alt_k ? K28_5_RDP : K28_5_RDN, viol);
      alt_k = !alt_k;
    end
  endtask

  // K28.5 followed by D21.5, repeating.
  task automatic kd(input int n, input bit viol);
    for (int i = 0; i < n; i++) begin
      send_cg(kd_k ? D21_5 : K28_5_RDN, viol);
      kd_k = !kd_k;
    end
  endtask

  task automatic do_reset();
    #2;
    RST = 1'b1;
    DVI = 1'b0;
    #1;
    model_reset();
    chk("rst_dvo", 10'(DVO), 10'h000);
    chk("rst_do", DO, 10'h000);
    chk("rst_lock", 10'(LOCK), 10'h000);
    chk("rst_align_pos", 10'(ALIGN_POS), 10'h000);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  // From an empty aligner: lock at offset 3 after 2 fill words plus N_VERIFY+1 commas.
  task automatic lock_at_3();
    rot_r = 3;
    prev_cg = K28_5_RDP;
    alt_k = 0;
    alt(5, 0);
    chk("lock_not_early", 10'(LOCK), 10'h000);
    alt(1, 0);
    chk("lock_rise", 10'(LOCK), 10'h001);
    chk("lock_pos3", 10'(ALIGN_POS), 10'h003);
    for (int i = 0; i < 6; i++) begin
      alt(1, 0);
      chk("dvo_locked", 10'(DVO), 10'h001);
      chk("do_aligned", DO, sent[sent.size()-3]);
    end
  endtask

  initial begin
    RST = 1'b1; DVI = 1'b0; DI = '0; VIOL_IN = 1'b0;
    model_reset();
    #1;
    chk("rst_dvo", 10'(DVO), 10'h000);
    chk("rst_do", DO, 10'h000);
    chk("rst_lock", 10'(LOCK), 10'h000);
    chk("rst_align_pos", 10'(ALIGN_POS), 10'h000);
    repeat (2) @(negedge CLK);
    RST = 1'b0;

    lock_at_3();

    // Error exit: 3 bad, 1 good, then 4 consecutive bad words drop lock.
    alt(3, 1);
    chk("err_burst_hold", 10'(LOCK), 10'h001);
    alt(1, 0);
    alt(3, 1);
    chk("err_3_hold", 10'(LOCK), 10'h001);
    alt(1, 1);
    chk("err_4_drop", 10'(LOCK), 10'h000);
    alt(8, 0);
    chk("relock", 10'(LOCK), 10'h001);
    chk("relock_pos", 10'(ALIGN_POS), 10'h003);

    // Offset 0 with data; the decoder flags the misaligned words during the switch.
    rot_r = 0;
    kd_k = 0;
    kd(6, 1);
    kd(24, 0);
    chk("off0_lock", 10'(LOCK), 10'h001);
    chk("off0_pos", 10'(ALIGN_POS), 10'h000);
    for (int i = 0; i < 4; i++) begin
      kd(1, 0);
      chk("off0_do", DO, sent[sent.size()-3]);
    end

    // Mid-lock reset, then the full lock sequence again.
    do_reset();
    lock_at_3();

    // VERIFY abort: one comma at offset 5, then commas at offset 2 only.
    do_reset();
    rot_r = 5;
    prev_cg = D21_5;
    send_cg(D21_5, 0);
    send_cg(D21_5, 0);
    send_cg(K28_5_RDN, 0);
    for (int i = 0; i < 3; i++) send_cg(D21_5, 0);
    chk("ver5_pos", 10'(ALIGN_POS), 10'h005);
    chk("ver5_nolock", 10'(LOCK), 10'h000);
    rot_r = 2;
    send_cg(D21_5, 0);
    kd_k = 0;
    kd(4, 0);
    chk("abort_nolock", 10'(LOCK), 10'h000);
    kd(12, 0);
    chk("ver2_lock", 10'(LOCK), 10'h001);
    chk("ver2_pos", 10'(ALIGN_POS), 10'h002);

    // DVI gaps: one DVO per DVI, nothing advances on idle cycles.
    for (int i = 0; i < 10; i++) begin
      kd(1, 0);
      if (i > 0) chk("gap_dvo_idle", 10'(DVO), 10'h000);
      step(1'b0, 10'($urandom), 1'b0);
      chk("gap_dvo", 10'(DVO), 10'h001);
      chk("gap_do", DO, sent[sent.size()-2]);
    end
    chk("gap_lock", 10'(LOCK), 10'h001);
    chk("gap_pos", 10'(ALIGN_POS), 10'h002);

    // Randomized traffic: gaps, violations, raw data words, occasional bit slips and a reset.
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      if ($urandom_range(99) == 0) rot_r = $urandom_range(9);
      if ($urandom_range(15) < 3) begin
        step(1'b0, 10'($urandom), $urandom_range(3) == 0);
      end else if ($urandom_range(7) == 0) begin
        send_cg(10'($urandom), $urandom_range(19) == 0);
      end else begin
        kd(1, $urandom_range(19) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/comma_aligner_10b.md
# comma_aligner_10b

Word aligner that sits directly upstream of the 8b/10b decoder. It takes raw, arbitrarily bit-rotated 10-bit words from the deserializer and searches every bit offset for the K28.x comma. It locks onto the comma boundary and delivers code-group-aligned words on the decoder's `DVI`/`DI` inputs. The decoder's `VIOL` output is fed back so that loss of alignment triggers a re-hunt.

## Interface
- `N_VERIFY`, default 3: additional commas at the candidate offset required to go from VERIFY to LOCKED.
- `ERR_LIMIT`, default 4: consecutive bad words in LOCKED that force a return to HUNT.
- `CLK  input  1`: single clock; all state updates on the rising edge.
- `RST  input  1`: asynchronous, active-high reset.
- `DVI  input  1`: raw word valid, one per deserializer word.
- `DI  input  10`: raw word; `DI[9]` is the earliest received bit.
- `VIOL_IN  input  1`: decoder violation flag for the word currently on `DO`. Sampled only when `DVO`=1.
- `DVO  output  1`: aligned word valid. Drives the decoder's `DVI`.
- `DO  output  10`: aligned code group `{a,b,c,d,e,i,f,g,h,j}`. Drives the decoder's `DI`.
- `LOCK  output  1`: high in LOCKED state.
- `ALIGN_POS  output  4`: current bit offset, 0..9.

## Operation
- **Window register `win[19:0]`.**
  - On each `DVI`=1 edge: `win <= {win[9:0], DI}`.
  - A 2-bit fill counter saturates at 2. `wv` = 1 once fill is 2 and `DVI` was high on the previous edge.
- **Candidates.**
  - `cand[p] = win[19-p -: 10]` for p = 0..9.
  - `hit[p]` = 1 when `cand[p][9:3]` equals 7'b0011111 or 7'b1100000.
  - First hit = lowest p with `hit[p]`=1.
- **States HUNT, VERIFY, LOCKED**; `cnt` counter. All transitions are evaluated only on edges where `wv`=1.
- **HUNT.**
  - Any hit → VERIFY, `pos` <= first hit, `cnt` <= 0.
  - No hit → stay.
- **VERIFY.**
  - `hit[pos]` → `cnt`+1; when `cnt`+1 = `N_VERIFY` → LOCKED, `cnt` <= 0.
  - Hit at any other offset without `hit[pos]` → HUNT.
  - No hit → stay; `cnt` held.
- **LOCKED.**
  - Bad word: (`DVO` & `VIOL_IN`), or a hit at an offset ≠ `pos` without `hit[pos]`.
    - Bad word → `cnt`+1; reaching `ERR_LIMIT` → HUNT, `cnt` <= 0.
  - Good word: `DVO` & ~`VIOL_IN` with no foreign comma → `cnt` <= 0.
  - `pos` is never changed in LOCKED.
- **Outputs.**
  - On a `wv` edge: `DO <= cand[pos]` using `pos` before the edge; `DVO <=` (state before edge == LOCKED).
  - Otherwise `DVO` <= 0 and `DO` is held.
  - `LOCK` and `ALIGN_POS` are registered copies of state == LOCKED and `pos`.
- **Reset values.**
  - Outputs: `DVO`=0, `DO`=0, `LOCK`=0, `ALIGN_POS`=0.
  - Internal: `win`=0, fill=0, state=HUNT, `cnt`=0, `pos`=0.

## Timing
- **Latency:** the raw word presented with `DVI` at edge k enters `win`. The aligned word whose last bits came from it appears on `DO`/`DVO` after edge k+1, so latency is 2 clocks.
- **Throughput:** at most one `DVO` per `DVI`, with no bubbles added. `DVI` gaps are passed through as `DVO` gaps.
- **`VIOL_IN`:** combinational from `DO`, so it belongs to the same cycle as `DVO`.
- **First `DVO` after lock:** on the first `wv` edge following the edge that entered LOCKED.
- **Counter widths:** `cnt` width is `$clog2(max(N_VERIFY, ERR_LIMIT)+1)`. It never wraps: it is cleared on each state change.
- **Simultaneous events:** `hit[pos]` together with foreign hits counts as a good comma, not an error.
- **Reset:** `RST` asserted mid-stream clears everything asynchronously. After release, the first `DVO` requires refill of 2 words plus `N_VERIFY`+1 commas.

## Structure
- **Package `enc_8b10b_pkg`:**
  - `COMMA_RDN` = 7'b0011111 and `COMMA_RDP` = 7'b1100000.
  - `K28_5_RDN` = 10'b0011111010 and `K28_5_RDP` = 10'b1100000101.
  - `align_state_t` enum {HUNT, VERIFY, LOCKED}.
- **Sub-module `comma_detect_10b`:** purely combinational, `win[19:0]` → `hit[9:0]`, reusable by the transmit-side checker.
- **Top `comma_aligner_10b`:** window, FSM, counters, output registers.

## Test plan
- **Lock at offset 3:** continuous `DVI`; alternating `K28_5_RDN`/`K28_5_RDP` bit stream rotated so each `DI` holds 3 trailing + 7 leading bits → `ALIGN_POS`=3.
  - `LOCK` rises after 2 fill words + 4 commas (N_VERIFY=3).
  - `DO` then alternates 10'h0FA / 10'h305.
- **Offset 0 with data:** aligned K28.5 followed by D21.5 (10'b1010101010) → `ALIGN_POS`=0, `DO` bit-exact to input delayed 2 clocks.
- **Error exit:** in LOCKED, drive `VIOL_IN`=1 on 3 `DVO` words, then 1 good, then 4 bad → `LOCK` stays 1 through the first burst and drops after the 4th consecutive bad word.
- **VERIFY abort:** comma at offset 5, then comma at offset 2 only → returns to HUNT and re-verifies at 2. `LOCK` never asserts early.
- **`DVI` gaps:** `DVI` toggling 1/0 → one `DVO` per `DVI`, no state advance on idle cycles.
- **Mid-lock reset:** assert `RST` while locked → `DVO`/`LOCK`/`DO`/`ALIGN_POS` all 0 immediately, re-lock per the first scenario.
